msrv32_wb_stage: RTL and testbench

- Write-back stage of the msrv32 pipeline, directly upstream of the integer register file.
- Captures the retiring instruction from execute and selects the result source (ALU, load, CSR, immediate, PC+4).
- Aligns and sign/zero-extends load data, and stalls upstream while a load waits for data-memory acknowledge.
- Drives the register file write port: wr_en, rd_addr, rd data, registered.

---
 rtl/msrv32_wb_stage_if.sv | 33 +++
 rtl/msrv32_wb_stage.sv | 139 +++++++++++++
 tb/tb_msrv32_wb_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_wb_stage_if.sv
// Bundle between execute, data memory and the register-file write port of msrv32_wb_stage.
// master = environment (execute/dmem/regfile side), slave = the write-back stage itself.
interface msrv32_wb_stage_if;
   logic        ex_valid_in;
   logic [4:0]  ex_rd_addr_in;
   logic [2:0]  ex_wb_sel_in;
   logic [31:0] ex_alu_result_in;
   logic [2:0]  ex_load_funct3_in;
   logic [31:0] ex_csr_data_in;
   logic [31:0] ex_imm_in;
   logic [31:0] ex_pc_plus_4_in;
   logic [31:0] dmem_rdata_in;
   logic        dmem_ack_in;
   logic        stall_out;
   logic        wr_en_out;
   logic [4:0]  rd_addr_out;
   logic [31:0] rd_out;
   logic        load_fault_out;

   modport master (
      output ex_valid_in, ex_rd_addr_in, ex_wb_sel_in, ex_alu_result_in,
             ex_load_funct3_in, ex_csr_data_in, ex_imm_in, ex_pc_plus_4_in,
             dmem_rdata_in, dmem_ack_in,
      input  stall_out, wr_en_out, rd_addr_out, rd_out, load_fault_out
   );

   modport slave (
      input  ex_valid_in, ex_rd_addr_in, ex_wb_sel_in, ex_alu_result_in,
             ex_load_funct3_in, ex_csr_data_in, ex_imm_in, ex_pc_plus_4_in,
             dmem_rdata_in, dmem_ack_in,
      output stall_out, wr_en_out, rd_addr_out, rd_out, load_fault_out
   );
endinterface

// File: rtl/msrv32_wb_stage.sv
// msrv32 write-back stage: result select, load alignment/extension, registered regfile write.
// Optional load timeout fault enabled by defining MSRV32_LOAD_TIMEOUT_EN.
module msrv32_wb_stage #(
   parameter int LOAD_TIMEOUT = 16
) (
   input logic                ms_riscv32_mp_clk_in,
   input logic                ms_riscv32_mp_rst_in,
   msrv32_wb_stage_if.slave   wb
);
   localparam logic [0:0] IDLE      = 1'b0;
   localparam logic [0:0] WAIT_LOAD = 1'b1;

   localparam logic [2:0] SEL_ALU  = 3'b000;
   localparam logic [2:0] SEL_LOAD = 3'b001;
   localparam logic [2:0] SEL_CSR  = 3'b010;
   localparam logic [2:0] SEL_IMM  = 3'b011;
   localparam logic [2:0] SEL_PC4  = 3'b100;

   logic [0:0]  state_reg;
   logic        wr_en_reg;
   logic [4:0]  rd_addr_reg;
   logic [31:0] rd_reg;
   logic [4:0]  ld_rd_addr_reg;
   logic [2:0]  ld_funct3_reg;
   logic [1:0]  ld_off_reg;

   logic [31:0] result_next;
   logic        sel_ok_next;
   logic [31:0] load_next;
   logic [7:0]  byte_lane [4];
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign byte_lane[gi] = wb.dmem_rdata_in[8*gi +: 8];
      end
   endgenerate

   assign ld_byte = byte_lane[ld_off_reg];
   // Halfword position comes from off[1] only; misaligned halves are trapped upstream.
   assign ld_half = ld_off_reg[1] ? wb.dmem_rdata_in[31:16] : wb.dmem_rdata_in[15:0];

   always_comb begin
      load_next = wb.dmem_rdata_in;
      case (ld_funct3_reg)
         3'b000:  load_next = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_next = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_next = {24'd0, ld_byte};
         3'b101:  load_next = {16'd0, ld_half};
         default: load_next = wb.dmem_rdata_in;
      endcase
   end

   always_comb begin
      result_next = 32'd0;
      sel_ok_next = 1'b1;
      case (wb.ex_wb_sel_in)
         SEL_ALU: result_next = wb.ex_alu_result_in;
         SEL_CSR: result_next = wb.ex_csr_data_in;
         SEL_IMM: result_next = wb.ex_imm_in;
         SEL_PC4: result_next = wb.ex_pc_plus_4_in;
         default: sel_ok_next = 1'b0;
      endcase
   end

`ifdef MSRV32_LOAD_TIMEOUT_EN
   localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
   logic [CNT_W-1:0] tmo_cnt_reg;
   logic             fault_reg;
   assign wb.load_fault_out = fault_reg;
`else
   assign wb.load_fault_out = 1'b0;
`endif

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) begin
         state_reg      <= IDLE;
         wr_en_reg      <= 1'b0;
         rd_addr_reg    <= 5'd0;
         rd_reg         <= 32'd0;
         ld_rd_addr_reg <= 5'd0;
         ld_funct3_reg  <= 3'd0;
         ld_off_reg     <= 2'd0;
`ifdef MSRV32_LOAD_TIMEOUT_EN
         tmo_cnt_reg    <= '0;
         fault_reg      <= 1'b0;
`endif
      end else begin
         wr_en_reg <= 1'b0;
`ifdef MSRV32_LOAD_TIMEOUT_EN
         fault_reg <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               if (wb.ex_valid_in) begin
                  if (wb.ex_wb_sel_in == SEL_LOAD) begin
                     ld_rd_addr_reg <= wb.ex_rd_addr_in;
                     ld_funct3_reg  <= wb.ex_load_funct3_in;
                     ld_off_reg     <= wb.ex_alu_result_in[1:0];
                     state_reg      <= WAIT_LOAD;
`ifdef MSRV32_LOAD_TIMEOUT_EN
                     tmo_cnt_reg    <= '0;
`endif
                  end else if (sel_ok_next) begin
                     wr_en_reg   <= (wb.ex_rd_addr_in != 5'd0);
                     rd_addr_reg <= wb.ex_rd_addr_in;
                     rd_reg      <= result_next;
                  end
               end
            end
            default: begin
               // Ack beats a simultaneous timeout.
               if (wb.dmem_ack_in) begin
                  wr_en_reg   <= (ld_rd_addr_reg != 5'd0);
                  rd_addr_reg <= ld_rd_addr_reg;
                  rd_reg      <= load_next;
                  state_reg   <= IDLE;
               end
`ifdef MSRV32_LOAD_TIMEOUT_EN
               else if (tmo_cnt_reg == CNT_W'(LOAD_TIMEOUT - 1)) begin
                  fault_reg   <= 1'b1;
                  state_reg   <= IDLE;
                  tmo_cnt_reg <= '0;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               end
`endif
            end
         endcase
      end
   end

   assign wb.stall_out   = (state_reg == WAIT_LOAD);
   assign wb.wr_en_out   = wr_en_reg;
   assign wb.rd_addr_out = rd_addr_reg;
   assign wb.rd_out      = rd_reg;
endmodule

// File: tb/tb_msrv32_wb_stage.sv
// Directed self-checking bench for msrv32_wb_stage; timeout case follows MSRV32_LOAD_TIMEOUT_EN.
module tb_msrv32_wb_stage;
   localparam int TMO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   msrv32_wb_stage_if wb_if ();

   msrv32_wb_stage #(.LOAD_TIMEOUT(TMO)) dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .wb                   (wb_if)
   );

   initial forever #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] sel, input logic [4:0] rd, input logic [31:0] val);
      wb_if.ex_valid_in      = 1'b1;
      wb_if.ex_wb_sel_in     = sel;
      wb_if.ex_rd_addr_in    = rd;
      wb_if.ex_alu_result_in = val;
      wb_if.ex_csr_data_in   = val;
      wb_if.ex_imm_in        = val;
      wb_if.ex_pc_plus_4_in  = val;
   endtask

   // Load with 'waits' ack-less cycles; an ALU op is driven during the wait and must be ignored.
   task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] data, input int waits,
                          input logic [31:0] exp);
      issue(3'b001, rd, {30'd0, off});
      wb_if.ex_load_funct3_in = f3;
      tick;
      check_eq({tag, "_stall0"}, 32'(wb_if.stall_out), 32'd1);
      check_eq({tag, "_nowr0"}, 32'(wb_if.wr_en_out), 32'd0);
      issue(3'b000, 5'd31, 32'hDEAD_BEEF);
      for (int i = 0; i < waits; i++) begin
         tick;
         check_eq({tag, "_stallw"}, 32'(wb_if.stall_out), 32'd1);
         check_eq({tag, "_nowrw"}, 32'(wb_if.wr_en_out), 32'd0);
      end
      wb_if.ex_valid_in   = 1'b0;
      wb_if.dmem_ack_in   = 1'b1;
      wb_if.dmem_rdata_in = data;
      tick;
      wb_if.dmem_ack_in = 1'b0;
      check_eq({tag, "_wr"}, 32'(wb_if.wr_en_out), (rd != 5'd0) ? 32'd1 : 32'd0);
      check_eq({tag, "_addr"}, 32'(wb_if.rd_addr_out), 32'(rd));
      check_eq({tag, "_data"}, wb_if.rd_out, exp);
      check_eq({tag, "_stall"}, 32'(wb_if.stall_out), 32'd0);
   endtask

   initial begin
      wb_if.ex_valid_in       = 1'b0;
      wb_if.ex_rd_addr_in     = 5'd0;
      wb_if.ex_wb_sel_in      = 3'd0;
      wb_if.ex_alu_result_in  = 32'd0;
      wb_if.ex_load_funct3_in = 3'd0;
      wb_if.ex_csr_data_in    = 32'd0;
      wb_if.ex_imm_in         = 32'd0;
      wb_if.ex_pc_plus_4_in   = 32'd0;
      wb_if.dmem_rdata_in     = 32'd0;
      wb_if.dmem_ack_in       = 1'b0;
      rst = 1'b1;
      tick;
      tick;
      check_eq("rst_wr", 32'(wb_if.wr_en_out), 32'd0);
      check_eq("rst_addr", 32'(wb_if.rd_addr_out), 32'd0);
      check_eq("rst_data", wb_if.rd_out, 32'd0);
      check_eq("rst_stall", 32'(wb_if.stall_out), 32'd0);
      check_eq("rst_fault", 32'(wb_if.load_fault_out), 32'd0);
      rst = 1'b0;

      // ALU op, then idle hold
      issue(3'b000, 5'd5, 32'h1234_5678);
      tick;
      check_eq("alu_wr", 32'(wb_if.wr_en_out), 32'd1);
      check_eq("alu_addr", 32'(wb_if.rd_addr_out), 32'd5);
      check_eq("alu_data", wb_if.rd_out, 32'h1234_5678);
      check_eq("alu_stall", 32'(wb_if.stall_out), 32'd0);
      wb_if.ex_valid_in = 1'b0;
      tick;
      check_eq("idle_wr", 32'(wb_if.wr_en_out), 32'd0);
      check_eq("idle_hold", wb_if.rd_out, 32'h1234_5678);

      // Loads: stall for 1+waits cycles, then aligned/extended write
      do_load("lb",  5'd7,  3'b000, 2'b11, 32'h80FF_0000, 3, 32'hFFFF_FF80);
      do_load("lhu", 5'd10, 3'b101, 2'b10, 32'h8001_1234, 0, 32'h0000_8001);
      do_load("lh",  5'd11, 3'b001, 2'b10, 32'h8001_1234, 1, 32'hFFFF_8001);
      do_load("lbu", 5'd12, 3'b100, 2'b01, 32'h8001_1234, 0, 32'h0000_0012);
      do_load("lw",  5'd13, 3'b010, 2'b00, 32'h8001_1234, 0, 32'h8001_1234);
      do_load("lhlo", 5'd14, 3'b001, 2'b00, 32'h0000_F00D, 0, 32'hFFFF_F00D);
      do_load("f3und", 5'd15, 3'b111, 2'b11, 32'hCAFE_0001, 0, 32'hCAFE_0001);
      do_load("ldx0", 5'd0, 3'b010, 2'b00, 32'h5555_AAAA, 2, 32'h5555_AAAA);

      // x0 suppression, then back-to-back writes
      issue(3'b100, 5'd0, 32'h0000_0100);
      tick;
      check_eq("x0_wr", 32'(wb_if.wr_en_out), 32'd0);
      check_eq("x0_data", wb_if.rd_out, 32'h0000_0100);
      issue(3'b000, 5'd3, 32'h0000_0033);
      tick;
      check_eq("b2b1_wr", 32'(wb_if.wr_en_out), 32'd1);
      check_eq("b2b1_addr", 32'(wb_if.rd_addr_out), 32'd3);
      issue(3'b000, 5'd4, 32'h0000_0044);
      tick;
      check_eq("b2b2_wr", 32'(wb_if.wr_en_out), 32'd1);
      check_eq("b2b2_addr", 32'(wb_if.rd_addr_out), 32'd4);
      check_eq("b2b2_data", wb_if.rd_out, 32'h0000_0044);

      // CSR and IMM sources; ack in IDLE must be ignored
      wb_if.dmem_ack_in = 1'b1;
      issue(3'b010, 5'd6, 32'h0000_C5C5);
      tick;
      check_eq("csr_data", wb_if.rd_out, 32'h0000_C5C5);
      check_eq("csr_stall", 32'(wb_if.stall_out), 32'd0);
      wb_if.dmem_ack_in = 1'b0;
      issue(3'b011, 5'd8, 32'h1234_5000);
      tick;
      check_eq("imm_addr", 32'(wb_if.rd_addr_out), 32'd8);
      check_eq("imm_data", wb_if.rd_out, 32'h1234_5000);

      // Reserved select: no write, outputs hold
      issue(3'b101, 5'd9, 32'h7777_7777);
      tick;
      check_eq("rsv_wr", 32'(wb_if.wr_en_out), 32'd0);
      check_eq("rsv_addr", 32'(wb_if.rd_addr_out), 32'd8);
      check_eq("rsv_stall", 32'(wb_if.stall_out), 32'd0);

      // Reset while waiting for a load
      issue(3'b001, 5'd13, 32'd0);
      wb_if.ex_load_funct3_in = 3'b010;
      tick;
      check_eq("rml_stall", 32'(wb_if.stall_out), 32'd1);
      wb_if.ex_valid_in = 1'b0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check_eq("rml_stall_rst", 32'(wb_if.stall_out), 32'd0);
      wb_if.dmem_ack_in   = 1'b1;
      wb_if.dmem_rdata_in = 32'h1111_2222;
      tick;
      wb_if.dmem_ack_in = 1'b0;
      check_eq("rml_nowr", 32'(wb_if.wr_en_out), 32'd0);
      check_eq("rml_data", wb_if.rd_out, 32'd0);
      check_eq("rml_stall_ack", 32'(wb_if.stall_out), 32'd0);

      // Load that never gets an ack
      issue(3'b001, 5'd14, 32'd0);
      wb_if.ex_load_funct3_in = 3'b010;
      tick;
      wb_if.ex_valid_in = 1'b0;
`ifdef MSRV32_LOAD_TIMEOUT_EN
      for (int i = 0; i < TMO - 1; i++) begin
         check_eq("tmo_stall", 32'(wb_if.stall_out), 32'd1);
         check_eq("tmo_nofault", 32'(wb_if.load_fault_out), 32'd0);
         tick;
      end
      check_eq("tmo_stall_last", 32'(wb_if.stall_out), 32'd1);
      tick;
      check_eq("tmo_fault", 32'(wb_if.load_fault_out), 32'd1);
      check_eq("tmo_nowr", 32'(wb_if.wr_en_out), 32'd0);
      check_eq("tmo_stall_drop", 32'(wb_if.stall_out), 32'd0);
      tick;
      check_eq("tmo_pulse_end", 32'(wb_if.load_fault_out), 32'd0);
`else
      for (int i = 0; i < 20; i++) begin
         tick;
         check_eq("notmo_stall", 32'(wb_if.stall_out), 32'd1);
         check_eq("notmo_fault", 32'(wb_if.load_fault_out), 32'd0);
      end
      wb_if.dmem_ack_in   = 1'b1;
      wb_if.dmem_rdata_in = 32'hABCD_0123;
      tick;
      wb_if.dmem_ack_in = 1'b0;
      check_eq("notmo_wr", 32'(wb_if.wr_en_out), 32'd1);
      check_eq("notmo_data", wb_if.rd_out, 32'hABCD_0123);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
